// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - 32-LED mode sequencer: debounced buttons driving COUNT/SCAN/BREATHE/OFF patterns
// Build option LED_GAMMA_EN: BREATHE uses (duty*duty)>>8 instead of a linear duty.
module led_mode_sequencer #(
  parameter int TICK_DIV       = 1000000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_pause,
  output logic [7:0]  LED,
  output logic [23:0] IO_LED,
  output logic [1:0]  mode,
  output logic        paused
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    S_COUNT   = 2'd0,
    S_SCAN    = 2'd1,
    S_BREATHE = 2'd2,
    S_OFF     = 2'd3
  } state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  // Bit 0 is the next button, bit 1 the pause button.
  logic [1:0]    sync1, sync2, deb, press;
  logic [DW-1:0] deb_cnt [2];

  state_t      state, state_nxt;
  logic        pause_flag, pause_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [4:0]  pos, pos_nxt;
  logic        dir, dir_nxt;
  logic [7:0]  duty, duty_nxt;
  logic        ramp, ramp_nxt;
  logic [7:0]  pwm;
  logic [7:0]  duty_eff;
  logic [31:0] display_nxt;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      pwm      <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      pwm      <= pwm + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_pause, btn_next};
      sync2 <= sync1;
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (sync2[i] != deb[i]) begin
            if (deb_cnt[i] == DEB_LAST) begin
              deb[i]     <= sync2[i];
              deb_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
          end else begin
            deb_cnt[i] <= '0;
          end
        end
      end
    end
  end

  // A press fires in the very cycle the debounced level is accepted as 1.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = tick && sync2[i] && !deb[i] && (deb_cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_COUNT;
      pause_flag <= 1'b0;
      cnt        <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      duty       <= '0;
      ramp       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pause_flag <= pause_nxt;
      cnt        <= cnt_nxt;
      pos        <= pos_nxt;
      dir        <= dir_nxt;
      duty       <= duty_nxt;
      ramp       <= ramp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pause_nxt = pause_flag;
    cnt_nxt   = cnt;
    pos_nxt   = pos;
    dir_nxt   = dir;
    duty_nxt  = duty;
    ramp_nxt  = ramp;

    if (press[1]) pause_nxt = !pause_flag;

    // A mode change clears the pattern and overrides any same-cycle advance.
    if (press[0]) begin
      case (state)
        S_COUNT:   state_nxt = S_SCAN;
        S_SCAN:    state_nxt = S_BREATHE;
        S_BREATHE: state_nxt = S_OFF;
        default:   state_nxt = S_COUNT;
      endcase
      cnt_nxt  = '0;
      pos_nxt  = '0;
      dir_nxt  = 1'b0;
      duty_nxt = '0;
      ramp_nxt = 1'b0;
    end else if (tick && !pause_flag) begin
      case (state)
        S_COUNT: cnt_nxt = cnt + 32'd1;
        S_SCAN: begin
          if (!dir) begin
            if (pos == 5'd31) begin
              pos_nxt = 5'd30;
              dir_nxt = 1'b1;
            end else begin
              pos_nxt = pos + 5'd1;
            end
          end else if (pos == 5'd0) begin
            pos_nxt = 5'd1;
            dir_nxt = 1'b0;
          end else begin
            pos_nxt = pos - 5'd1;
          end
        end
        S_BREATHE: begin
          if (!ramp) begin
            if (duty == 8'd255) begin
              duty_nxt = 8'd254;
              ramp_nxt = 1'b1;
            end else begin
              duty_nxt = duty + 8'd1;
            end
          end else if (duty == 8'd0) begin
            duty_nxt = 8'd1;
            ramp_nxt = 1'b0;
          end else begin
            duty_nxt = duty - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_GAMMA_EN
  assign duty_eff = 8'(({8'd0, duty} * {8'd0, duty}) >> 8);
`else
  assign duty_eff = duty;
`endif

  always_comb begin
    display_nxt = '0;
    case (state)
      S_COUNT:   display_nxt = cnt;
      S_SCAN:    display_nxt = 32'd1 << pos;
      S_BREATHE: display_nxt = {32{pwm < duty_eff}};
      default:   display_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LED    <= '0;
      IO_LED <= '0;
      mode   <= 2'd0;
      paused <= 1'b0;
    end else begin
      {LED, IO_LED} <= display_nxt;
      mode          <= state;
      paused        <= pause_flag;
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - directed bench for led_mode_sequencer with TICK_DIV=4, DEBOUNCE_TICKS=2
module tb_led_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_pause = 1'b0;
  logic [7:0]  LED;
  logic [23:0] IO_LED;
  logic [1:0]  mode;
  logic        paused;
  logic [31:0] disp;

  int total = 0;
  int bad   = 0;

  assign disp = {LED, IO_LED};

  always #5 clk = ~clk;

  led_mode_sequencer #(.TICK_DIV(4), .DEBOUNCE_TICKS(2)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_pause(btn_pause),
    .LED(LED), .IO_LED(IO_LED), .mode(mode), .paused(paused)
  );

  // Bench stays one clock after a tick edge; each tick is 4 clocks away.
  task automatic step_ticks(input int n);
    repeat (4 * n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (LED !== 8'h00) begin bad++; $display("FAIL reset_led got=%h want=00", LED); end
    total++; if (IO_LED !== 24'h0) begin bad++; $display("FAIL reset_io_led got=%h want=000000", IO_LED); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL reset_paused got=%0d want=0", paused); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_count;
    repeat (40) @(posedge clk);
    #1;
    total++; if (disp !== 32'h9) begin bad++; $display("FAIL count_latency got=%h want=00000009", disp); end
    @(posedge clk);
    #1;
    total++; if (disp !== 32'hA) begin bad++; $display("FAIL count_10 got=%h want=0000000a", disp); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL count_mode got=%0d want=0", mode); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL count_paused got=%0d want=0", paused); end
  endtask

  task automatic test_scan;
    btn_next = 1'b1;
    step_ticks(2);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL scan_mode got=%0d want=1", mode); end
    total++; if (disp !== 32'h1) begin bad++; $display("FAIL scan_start got=%h want=00000001", disp); end
    step_ticks(1);
    total++; if (disp !== 32'h2) begin bad++; $display("FAIL scan_pos1 got=%h want=00000002", disp); end
    btn_next = 1'b0;
    step_ticks(30);
    total++; if (disp !== 32'h80000000) begin bad++; $display("FAIL scan_top got=%h want=80000000", disp); end
    step_ticks(1);
    total++; if (disp !== 32'h40000000) begin bad++; $display("FAIL scan_bounce got=%h want=40000000", disp); end
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL scan_single_press got=%0d want=1", mode); end
  endtask

  task automatic test_glitch;
    btn_next = 1'b1;
    step_ticks(1);
    btn_next = 1'b0;
    step_ticks(3);
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL glitch_next_mode got=%0d want=1", mode); end
    total++; if (disp !== 32'h04000000) begin bad++; $display("FAIL glitch_next_pos got=%h want=04000000", disp); end
    btn_pause = 1'b1;
    step_ticks(1);
    btn_pause = 1'b0;
    step_ticks(3);
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL glitch_pause got=%0d want=0", paused); end
    total++; if (disp !== 32'h00400000) begin bad++; $display("FAIL glitch_pause_pos got=%h want=00400000", disp); end
  endtask

  task automatic test_pause;
    step_ticks(25);
    btn_pause = 1'b1;
    step_ticks(2);
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL pause_set got=%0d want=1", paused); end
    total++; if (disp !== 32'h20) begin bad++; $display("FAIL pause_pos5 got=%h want=00000020", disp); end
    btn_pause = 1'b0;
    step_ticks(20);
    total++; if (disp !== 32'h20) begin bad++; $display("FAIL pause_hold got=%h want=00000020", disp); end
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL pause_hold_flag got=%0d want=1", paused); end
    btn_pause = 1'b1;
    step_ticks(2);
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL pause_clear got=%0d want=0", paused); end
    total++; if (disp !== 32'h20) begin bad++; $display("FAIL pause_no_step got=%h want=00000020", disp); end
    btn_pause = 1'b0;
    step_ticks(1);
    total++; if (disp !== 32'h40) begin bad++; $display("FAIL pause_resume got=%h want=00000040", disp); end
  endtask

  task automatic test_breathe;
    int ones;
    int odd;
    int want;
    btn_next = 1'b1;
    step_ticks(2);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL breathe_mode got=%0d want=2", mode); end
    total++; if (disp !== 32'h0) begin bad++; $display("FAIL breathe_dark got=%h want=00000000", disp); end
    btn_next = 1'b0;
    step_ticks(126);
    btn_pause = 1'b1;
    step_ticks(2);
    total++; if (paused !== 1'b1) begin bad++; $display("FAIL breathe_paused got=%0d want=1", paused); end
    btn_pause = 1'b0;
    ones = 0;
    odd  = 0;
    repeat (256) begin
      @(posedge clk);
      #1;
      if (disp === 32'hFFFFFFFF) ones++;
      else if (disp !== 32'h0) odd++;
    end
`ifdef LED_GAMMA_EN
    want = 64;
`else
    want = 128;
`endif
    total++; if (ones != want) begin bad++; $display("FAIL breathe_on_clocks got=%0d want=%0d", ones, want); end
    total++; if (odd != 0) begin bad++; $display("FAIL breathe_partial_words got=%0d want=0", odd); end
  endtask

  task automatic test_simultaneous;
    btn_next = 1'b1;
    step_ticks(2);
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL off_mode got=%0d want=3", mode); end
    total++; if (disp !== 32'h0) begin bad++; $display("FAIL off_dark got=%h want=00000000", disp); end
    btn_next = 1'b0;
    step_ticks(2);
    btn_next  = 1'b1;
    btn_pause = 1'b1;
    step_ticks(2);
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL both_mode got=%0d want=0", mode); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL both_paused got=%0d want=0", paused); end
    total++; if (disp !== 32'h0) begin bad++; $display("FAIL both_display got=%h want=00000000", disp); end
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    step_ticks(3);
    total++; if (disp !== 32'h3) begin bad++; $display("FAIL both_count got=%h want=00000003", disp); end
  endtask

  task automatic test_async_reset;
    rst = 1'b0;
    #1;
    total++; if (disp !== 32'h0) begin bad++; $display("FAIL areset_display got=%h want=00000000", disp); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL areset_mode got=%0d want=0", mode); end
    total++; if (paused !== 1'b0) begin bad++; $display("FAIL areset_paused got=%0d want=0", paused); end
    #20 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_count();
    test_scan();
    test_glitch();
    test_pause();
    test_breathe();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller that owns the 32-LED display bank (8 board LEDs + 24 IO-shield LEDs) and sequences what it shows. It takes two raw push-buttons, debounces them, and runs a mode FSM. The FSM selects between a free-running binary count, a bouncing one-hot scan, a PWM breathing pattern and all-off. It sits directly under top and drives LED/IO_LED in place of a bare counter.

Parameters:
TICK_DIV, 1000000, clk cycles per pattern tick (100 Hz at 100 MHz); legal range >= 2.
DEBOUNCE_TICKS, 4, consecutive ticks a synchronized button level must hold before it is accepted; legal range >= 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_next  input  1  raw, asynchronous button; press advances mode
btn_pause  input  1  raw, asynchronous button; press toggles pause
LED  output  8  board LEDs = display[31:24]
IO_LED  output  24  shield LEDs = display[23:0]
mode  output  2  current mode: 0 COUNT, 1 SCAN, 2 BREATHE, 3 OFF
paused  output  1  pause flag

Behaviour:
- Reset: rst low asynchronously clears all state. LED=0, IO_LED=0, mode=COUNT, paused=0. Prescaler, pattern counter, scan pos=0, dir=up, duty=0, ramp=up, pwm counter, synchronizers and debounced levels all 0. Release is synchronous to clk.
- Prescaler: tick_cnt runs 0..TICK_DIV-1 and wraps. tick is a 1-cycle pulse when tick_cnt==TICK_DIV-1. It runs regardless of mode or pause.
- Buttons: each button has a 2-FF synchronizer. The debounced level updates only on tick, once the synchronized level has differed from it for DEBOUNCE_TICKS consecutive ticks. A press event is a 1-clk pulse on a debounced 0->1 transition. Releases generate no event.
- Mode FSM: on next press, COUNT->SCAN->BREATHE->OFF->COUNT (wraps). In the same clock the mode register updates and all pattern state clears (cnt=0, pos=0, dir=up, duty=0, ramp=up). paused is unaffected.
- Pause: a pause press toggles paused. While paused, pattern state holds on tick. The PWM counter keeps running, so BREATHE holds brightness rather than going dark.
- Simultaneous next and pause press in the same cycle: both take effect (mode advances and pattern clears, paused toggles).
- A next press coinciding with a tick: the clear wins and no pattern advance happens that cycle.
- COUNT: 32-bit cnt increments by 1 per unpaused tick and wraps from 0xFFFFFFFF to 0. display = cnt.
- SCAN: pos 0..31, one-hot display = 1<<pos. pos advances one step per unpaused tick. Bounce sequence: 0,1,...,31,30,...,0,1. dir flips at the ends, so no endpoint is repeated.
- BREATHE: 8-bit duty ramps +1 per unpaused tick up to 255, then -1 down to 0, then up again; endpoints are not repeated. An 8-bit pwm counter increments every clk. All 32 display bits = (pwm < duty_eff). Duty 0 is fully off; 255 is on for 255 of 256 cycles.
- OFF: display = 0. Pattern state stays cleared.
- Outputs LED, IO_LED, mode and paused are registered. A state change is visible on the outputs exactly 1 clk later.

Optional Feature:
LED_GAMMA_EN
- Defined: duty_eff = (duty*duty)>>8, giving a perceptual gamma curve; 16-bit product, upper byte used.
- Undefined: duty_eff = duty (linear).
- No other behaviour changes.

Test Plan:
Bench uses TICK_DIV=4, DEBOUNCE_TICKS=2.
1. Reset, then 40 clk in COUNT -> ticks at clk 4,8,...; after 10 ticks {LED,IO_LED}=32'h0000000A; mode=0, paused=0.
2. btn_next high for 3 ticks -> exactly one press; mode=1; display=32'h00000001. After 31 more ticks display=32'h80000000; next tick 32'h40000000.
3. Glitch: btn_next high for 1 tick then low -> no press, mode unchanged. Repeat with btn_pause -> paused stays 0.
4. SCAN at pos 5, press pause -> paused=1; display holds 32'h00000020 for 20 ticks. Press pause again -> resumes at 32'h00000040 on the next tick.
5. In BREATHE, hold until duty=128, sample 256 clk -> display all-ones for 128 clk (linear). With LED_GAMMA_EN defined -> 64 clk.
6. In OFF, both buttons pressed in the same cycle -> mode=0, paused toggles, display=0. Assert rst mid-pattern -> all outputs 0 immediately without a clock edge.
